// File: rtl/async_pkg.sv
// Shared definitions for the async data-mux link: transmit FSM states and
// sizing helpers, also imported by the receiver-side monitors.
package async_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  // Width of a down-counter that must hold gap-1; never narrower than 1 bit.
  function automatic int cnt_w(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock payload FIFO with occupancy count; no write-to-read bypass,
// so a pushed entry is visible on rd_data one cycle after the push at earliest.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    push, pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    // Power-of-two depth lets the pointers wrap by plain overflow.
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/async_dmux_tx.sv
// Source side of a data-mux CDC link: queues payloads and emits each one as a
// registered d bus plus a one-cycle val_d pulse, with a forced idle gap after.
module async_dmux_tx
  import async_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int GAP   = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  output logic                   val_d,
  output logic [W-1:0]           d,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CW = cnt_w(GAP);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("async_dmux_tx: DEPTH must be a power of two >= 2");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("async_dmux_tx: GAP must be >= 1");
  end

  tx_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           val_d_q, val_d_d;
  logic [W-1:0]   d_q, d_d;

  logic           fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0]   fifo_rdata;

  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // val_d is a dedicated flop set on the IDLE->SEND edge, so it is high
  // exactly while the FSM sits in SEND and the receiver sees no comb path.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    val_d_d  = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          d_d      = fifo_rdata;
          val_d_d  = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        cnt_d   = CW'(GAP - 1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      val_d_q <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_d_q <= val_d_d;
      d_q     <= d_d;
    end
  end

  assign in_ready = !fifo_full;
  assign val_d    = val_d_q;
  assign d        = d_q;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_async_dmux_tx.sv
// Scoreboarded bench for async_dmux_tx: accepted payloads are queued at the
// push edge and matched against each val_d pulse, with timing checks around it.
module tb_async_dmux_tx;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int GAP   = 3;

  logic                   clk;
  logic                   rstn;
  logic                   in_valid;
  logic [W-1:0]           in_data;
  logic                   in_ready;
  logic                   val_d;
  logic [W-1:0]           d;
  logic                   busy;
  logic [$clog2(DEPTH):0] level;

  async_dmux_tx #(.W(W), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .val_d    (val_d),
    .d        (d),
    .busy     (busy),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } ent_t;

  ent_t     sb[$];
  int       pulses[$];
  int       lv[$];
  int       n_chk  = 0;
  int       n_fail = 0;
  int       cyc    = 0;
  int       last_pulse = -1;
  logic [W-1:0] last_d = '0;
  bit       log_en = 1'b0;
  int       stalls = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Push-side sampler: cyc is the index of the cycle ending at this edge.
  initial forever begin
    @(posedge clk);
    if (rstn && in_valid && in_ready) sb.push_back('{in_data, cyc});
    if (log_en && in_valid) lv.push_back(int'(level));
    cyc = cyc + 1;
  end

  // Output monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (val_d) begin
        pulses.push_back(cyc);
        if (last_pulse >= 0) chk("pulse_spacing", 64'((cyc - last_pulse) >= GAP + 2), 64'd1);
        last_pulse = cyc;
        if (sb.size() == 0) chk("unexpected_pulse", 64'(val_d), 64'd0);
        else begin
          ent_t e;
          e = sb.pop_front();
          chk("payload", 64'(d), 64'(e.data));
          chk("min_latency", 64'(cyc >= e.cyc + 2), 64'd1);
        end
        last_d = d;
      end else begin
        chk("d_hold", 64'(d), 64'(last_d));
      end
      chk("level_max", 64'(int'(level) <= DEPTH), 64'd1);
      if (level != 0) chk("busy_nonempty", 64'(busy), 64'd1);
    end
  end

  task automatic send(input logic [W-1:0] v, output int t);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    t = cyc;
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t;
    int maxlev, seen;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_val_d", 64'(val_d), 64'd0);
    chk("rst_d", 64'(d), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rstn = 1'b1;

    // Single push: pulse two cycles after the push cycle, d holds afterwards
    repeat (2) @(negedge clk);
    send(32'hA5A5_0001, t0);
    idle_in();
    chk("lat_t1_val_d", 64'(val_d), 64'd0);
    chk("lat_t1_level", 64'(level), 64'd1);
    chk("lat_t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("lat_t2_cycle", 64'(cyc), 64'(t0 + 2));
    chk("lat_t2_val_d", 64'(val_d), 64'd1);
    chk("lat_t2_d", 64'(d), 64'hA5A5_0001);
    @(negedge clk);
    chk("lat_t3_val_d", 64'(val_d), 64'd0);
    chk("lat_t3_d", 64'(d), 64'hA5A5_0001);
    wait_idle();

    // Back-to-back pushes: pulses every GAP+2 cycles, in order
    pulses.delete();
    send(32'd1, t0);
    send(32'd2, t);
    send(32'd3, t);
    send(32'd4, t);
    idle_in();
    wait_idle();
    chk("b2b_count", 64'(pulses.size()), 64'd4);
    if (pulses.size() == 4) begin
      chk("b2b_first", 64'(pulses[0]), 64'(t0 + 2));
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", 64'(pulses[i] - pulses[i-1]), 64'(GAP + 2));
    end

    // Fill to full with in_valid held: stall, no overflow, refill 4->3->4
    lv.delete();
    stalls = 0;
    log_en = 1'b1;
    for (int i = 0; i < 8; i++) send(32'hF000_0000 + 32'(i), t);
    idle_in();
    log_en = 1'b0;
    maxlev = 0;
    seen   = 0;
    foreach (lv[i]) if (lv[i] > maxlev) maxlev = lv[i];
    chk("fill_peak", 64'(maxlev), 64'(DEPTH));
    chk("fill_stalled", 64'(stalls > 0), 64'd1);
    for (int i = 0; i + 2 < lv.size(); i++) begin
      if (lv[i] == DEPTH && lv[i+1] == DEPTH - 1) begin
        seen++;
        chk("fill_refill", 64'(lv[i+2]), 64'(DEPTH));
      end
    end
    chk("fill_refill_seen", 64'(seen > 0), 64'd1);
    wait_idle();

    // Reset during GAP with two payloads queued
    send(32'hB000_0001, t0);
    send(32'hB000_0002, t);
    send(32'hB000_0003, t);
    idle_in();
    chk("pre_rst_level", 64'(level), 64'd2);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_val_d", 64'(val_d), 64'd0);
    chk("mid_rst_d", 64'(d), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    sb.delete();
    pulses.delete();
    last_pulse = -1;
    last_d     = '0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_pulses", 64'(pulses.size()), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Random traffic
    for (int i = 0; i < 100; i++) begin
      int gap_n;
      gap_n = int'($urandom_range(0, 3));
      for (int k = 0; k < gap_n; k++) idle_in();
      send(W'($urandom), t);
    end
    idle_in();
    wait_idle();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
